// File: rtl/sync_width_conv_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the width-converting FIFOs:
// ceil-log2, narrow/wide width and ratio derivation, and lane-select sizing.
package sync_width_conv_fifo_pkg;

  localparam int unsigned MAX_RATIO = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) bits = i + 1;
    end
    return bits;
  endfunction

  function automatic int unsigned narrow_width(input int unsigned w, input int unsigned r);
    return (w < r) ? w : r;
  endfunction

  function automatic int unsigned wide_width(input int unsigned w, input int unsigned r);
    return (w < r) ? r : w;
  endfunction

  function automatic int unsigned ratio_of(input int unsigned w, input int unsigned r);
    return wide_width(w, r) / narrow_width(w, r);
  endfunction

  // Storage units moved per transfer on a port of width 'side'.
  function automatic int unsigned units_per(input int unsigned side, input int unsigned w,
                                            input int unsigned r);
    return side / narrow_width(w, r);
  endfunction

  // Width of a lane index vector; kept at least 1 so declarations stay legal at RATIO=1.
  function automatic int unsigned lane_bits(input int unsigned ratio);
    return (ratio > 1) ? clog2(ratio) : 1;
  endfunction

  // Number of low pointer bits consumed by lane selection.
  function automatic int unsigned lane_shift(input int unsigned ratio);
    return clog2(ratio);
  endfunction

endpackage

// File: rtl/sync_width_conv_fifo_lane_ram.sv
// Lane-organised storage: ENTRIES words of LANES*LANE_W bits, per-lane write
// enables and a registered read port (block-RAM inferable with output reset).
module fifo_lane_ram
  import sync_width_conv_fifo_pkg::*;
#(
  parameter int unsigned LANE_W  = 8,
  parameter int unsigned LANES   = 2,
  parameter int unsigned ENTRIES = 512
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [clog2(ENTRIES)-1:0]    wr_addr,
  input  logic [LANES-1:0]             wr_lane_en,
  input  logic [LANES*LANE_W-1:0]      wr_data,
  input  logic                         rd_en,
  input  logic [clog2(ENTRIES)-1:0]    rd_addr,
  output logic [LANES*LANE_W-1:0]      rd_data
);

  logic [LANES*LANE_W-1:0] mem [ENTRIES];

  // Per-lane byte-enable style write; lanes not enabled keep their contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned lane = 0; lane < LANES; lane++) begin
        if (wr_lane_en[lane]) mem[wr_addr][lane*LANE_W +: LANE_W] <= wr_data[lane*LANE_W +: LANE_W];
      end
    end
  end

  // Registered read; the output register resets to zero and holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO with independent write and read widths (ratio 1, 2 or 4).
// Occupancy is tracked in narrow-width units; flags derive from registered Level.
module sync_width_conv_fifo
  import sync_width_conv_fifo_pkg::*;
#(
  parameter int unsigned W_WIDTH   = 16,
  parameter int unsigned R_WIDTH   = 8,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AF_THRESH = DEPTH - 16,
  parameter int unsigned AE_THRESH = 16
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Flush,
  input  logic [W_WIDTH-1:0]      Din,
  input  logic                    Wen,
  input  logic                    Ren,
  output logic [R_WIDTH-1:0]      Dout,
  output logic                    Dout_Valid,
  output logic                    Empty,
  output logic                    Full,
  output logic                    Almost_Empty,
  output logic                    Almost_Full,
  output logic [clog2(DEPTH):0]   Level,
  output logic                    Overflow,
  output logic                    Underflow
);

  localparam int unsigned NARROW_W   = narrow_width(W_WIDTH, R_WIDTH);
  localparam int unsigned WIDE_W     = wide_width(W_WIDTH, R_WIDTH);
  localparam int unsigned RATIO      = ratio_of(W_WIDTH, R_WIDTH);
  localparam int unsigned UW         = units_per(W_WIDTH, W_WIDTH, R_WIDTH);
  localparam int unsigned UR         = units_per(R_WIDTH, W_WIDTH, R_WIDTH);
  localparam int unsigned AW         = clog2(DEPTH);
  localparam int unsigned LVL_W      = AW + 1;
  localparam int unsigned LANE_IDX_W = lane_bits(RATIO);
  localparam int unsigned SHIFT      = lane_shift(RATIO);
  localparam int unsigned ENTRIES    = DEPTH / RATIO;

  localparam logic [LVL_W-1:0] UW_L    = LVL_W'(UW);
  localparam logic [LVL_W-1:0] UR_L    = LVL_W'(UR);
  localparam logic [LVL_W-1:0] FULL_AT = LVL_W'(DEPTH - UW);
  localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_THRESH);

  if (RATIO != 1 && RATIO != 2 && RATIO != MAX_RATIO) begin : g_bad_ratio
    $error("sync_width_conv_fifo: width ratio must be 1, 2 or 4");
  end

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 wr_go;
  logic                 rd_go;
  logic [WIDE_W-1:0]    ram_wdata;
  logic [WIDE_W-1:0]    ram_rdata;
  logic [RATIO-1:0]     ram_lane_en;

  // Status flags, all from the level registered at cycle start.
  always_comb begin
    Empty        = Level < UR_L;
    Full         = Level > FULL_AT;
    Almost_Empty = Level <= AE_L;
    Almost_Full  = Level >= AF_L;
  end

  // Acceptance uses cycle-start flags only, so neither side can bypass the other.
  always_comb begin
    wr_acc = Wen && !Full;
    rd_acc = Ren && !Empty;
    wr_go  = wr_acc && Rst_n && !Flush;
    rd_go  = rd_acc && Rst_n && !Flush;
  end

  // Pointers, level, read strobe and sticky error flags; flush clears like reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n || Flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Level      <= '0;
      Dout_Valid <= 1'b0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(UW);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(UR);
      Level      <= Level + (wr_acc ? UW_L : '0) - (rd_acc ? UR_L : '0);
      Dout_Valid <= rd_acc;
      if (Wen && Full)  Overflow  <= 1'b1;
      if (Ren && Empty) Underflow <= 1'b1;
    end
  end

  if (W_WIDTH >= R_WIDTH) begin : g_wide_write
    // A write fills a whole entry; Din's low unit lands in lane 0.
    always_comb begin
      ram_wdata   = Din;
      ram_lane_en = '1;
    end
  end else begin : g_narrow_write
    // A narrow write is replicated across lanes and only the pointer's lane is enabled.
    always_comb begin
      ram_wdata   = {RATIO{Din}};
      ram_lane_en = '0;
      ram_lane_en[wr_ptr[LANE_IDX_W-1:0]] = 1'b1;
    end
  end

  if (R_WIDTH >= W_WIDTH) begin : g_wide_read
    // A read returns a whole entry, oldest unit in the low lane.
    always_comb begin
      Dout = ram_rdata;
    end
  end else begin : g_narrow_read
    logic [LANE_IDX_W-1:0] rd_lane;

    // Lane of the last accepted read, held so Dout stays put between reads.
    always_ff @(posedge Clk) begin
      if (!Rst_n) rd_lane <= '0;
      else if (rd_go) rd_lane <= rd_ptr[LANE_IDX_W-1:0];
    end

    // Select the addressed lane from the registered RAM word.
    always_comb begin
      Dout = ram_rdata[32'(rd_lane)*R_WIDTH +: R_WIDTH];
    end
  end

  fifo_lane_ram #(
    .LANE_W  (NARROW_W),
    .LANES   (RATIO),
    .ENTRIES (ENTRIES)
  ) u_ram (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .wr_en      (wr_go),
    .wr_addr    (wr_ptr[AW-1:SHIFT]),
    .wr_lane_en (ram_lane_en),
    .wr_data    (ram_wdata),
    .rd_en      (rd_go),
    .rd_addr    (rd_ptr[AW-1:SHIFT]),
    .rd_data    (ram_rdata)
  );

endmodule
